fifo_word_packer: RTL

Read-side consumer of the asynchronous FIFO, in the `rd_clk` domain. It pops DATA_WIDTH-bit entries from the FIFO's first-word-fall-through read port and packs LANES consecutive entries into one wide output word, little-endian. Output uses a valid/ready handshake. A partially filled word is emitted with a lane mask on an idle timeout or on an explicit flush.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/packer_idle_timer.sv | 31 +++
 rtl/fifo_word_packer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side word packer.
package fifo_pkg;

    typedef enum logic {
        FILL = 1'b0,
        OUT  = 1'b1
    } packer_state_t;

    // Lane mask with the low cnt bits set, i.e. (1<<cnt)-1, for up to 16 lanes.
    function automatic logic [15:0] keep_mask(input logic [4:0] cnt);
        logic [16:0] w_mask;
        w_mask = (17'd1 << cnt) - 17'd1;
        return w_mask[15:0];
    endfunction

endpackage

// File: rtl/packer_idle_timer.sv
// Idle-cycle counter for the word packer; flags the cycle in which a partial
// word has sat untouched for TIMEOUT cycles.
module packer_idle_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_expire
);

    localparam int IW = $clog2(TIMEOUT + 1);

    logic [IW-1:0] r_idle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle <= '0;
        end else if (i_clear) begin
            r_idle <= '0;
        end else if (i_inc && (r_idle != IW'(TIMEOUT))) begin
            r_idle <= r_idle + IW'(1);
        end
    end

    // Fires on the idle cycle that would bring the count to TIMEOUT, so the
    // partial word is presented exactly TIMEOUT edges after the last pop.
    assign o_expire = i_inc && (r_idle == IW'(TIMEOUT - 1));

endmodule

// File: rtl/fifo_word_packer.sv
// Pops entries from a first-word-fall-through FIFO and packs LANES of them,
// little-endian, into one valid/ready output word with a contiguous lane mask.
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                          rd_clk,
    input  logic                          rd_rst_n,
    input  logic                          empty,
    input  logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          rd_en,
    input  logic                          flush,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [LANES*DATA_WIDTH-1:0]   m_data,
    output logic [LANES-1:0]              m_keep
);

    localparam int CW = $clog2(LANES + 1);
    localparam int MW = LANES * DATA_WIDTH;

    packer_state_t    r_state, w_state_next;
    logic [CW-1:0]    r_cnt, w_cnt_next;
    logic [MW-1:0]    r_data, w_data_next;
    logic [LANES-1:0] r_keep, w_keep_next;
    logic             w_pop;
    logic             w_hs;
    logic             w_timeout;
    logic             w_cnt_nz;

    assign m_valid  = (r_state == OUT);
    assign m_data   = r_data;
    assign m_keep   = r_keep;
    assign w_hs     = m_valid && m_ready;
    assign w_cnt_nz = (r_cnt != '0);

    // Combinational pop: back-pressure reaches the FIFO in the same cycle.
    assign rd_en = rd_rst_n && !empty && ((r_state == FILL) || w_hs);
    assign w_pop = rd_en;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_data_next  = r_data;
        w_keep_next  = r_keep;
        case (r_state)
            FILL: begin
                if (w_pop) begin
                    for (int i = 0; i < LANES; i++) begin
                        if (r_cnt == CW'(i)) begin
                            w_data_next[i*DATA_WIDTH +: DATA_WIDTH] = rd_data;
                        end
                    end
                    w_cnt_next = r_cnt + CW'(1);
                    if ((r_cnt + CW'(1)) == CW'(LANES)) begin
                        w_state_next = OUT;
                        w_keep_next  = '1;
                    end else if (flush && w_cnt_nz) begin
                        w_state_next = OUT;
                        w_keep_next  = LANES'(keep_mask(5'(r_cnt) + 5'd1));
                    end
                end else if (w_cnt_nz && (flush || w_timeout)) begin
                    w_state_next = OUT;
                    w_keep_next  = LANES'(keep_mask(5'(r_cnt)));
                end
            end
            OUT: begin
                if (w_hs) begin
                    // Clearing the lanes here keeps unused lanes of the next
                    // partial word at zero.
                    w_data_next  = '0;
                    w_keep_next  = '0;
                    w_cnt_next   = '0;
                    w_state_next = FILL;
                    if (w_pop) begin
                        w_data_next[DATA_WIDTH-1:0] = rd_data;
                        w_cnt_next = CW'(1);
                        if (LANES == 1) begin
                            w_state_next = OUT;
                            w_keep_next  = '1;
                        end
                    end
                end
            end
            default: w_state_next = FILL;
        endcase
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_state <= FILL;
            r_cnt   <= '0;
            r_data  <= '0;
            r_keep  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_data  <= w_data_next;
            r_keep  <= w_keep_next;
        end
    end

    generate
        if (TIMEOUT != 0) begin : g_timer
            logic w_idle_clear;
            logic w_idle_inc;

            assign w_idle_clear = w_pop || (w_state_next != r_state) || !w_cnt_nz;
            assign w_idle_inc   = (r_state == FILL) && w_cnt_nz && !w_pop;

            packer_idle_timer #(
                .TIMEOUT (TIMEOUT)
            ) u_idle_timer (
                .clk      (rd_clk),
                .rst_n    (rd_rst_n),
                .i_clear  (w_idle_clear),
                .i_inc    (w_idle_inc),
                .o_expire (w_timeout)
            );
        end else begin : g_no_timer
            assign w_timeout = 1'b0;
        end
    endgenerate

endmodule
